// File: rtl/bp_stall_histogram.sv
// bp_stall_histogram
//
// Bins the profiler's per-cycle classification into saturating counters:
// one counter per stall reason, a retired-instruction counter and an
// enabled-cycle counter. The live bank can be copied atomically into a
// shadow bank, which the host reads one word per request.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   en_i                  profiling enable; low freezes the live bank
//   instret_i             an instruction retired this cycle
//   reason_v_i, reason_i  stall reason code and its valid
//   snapshot_i            copy live bank (pre-update values) to shadow bank
//   clear_i               zero the live bank, dropping this cycle's event
//   rd_v_i, rd_addr_i     read request and shadow address
//   rd_ready_o            request accepted when high
//   rd_v_o, rd_data_o     read response, held until rd_yumi_i
//   rd_yumi_i             consumer takes the response
//
// Address map: 0..num_reasons_p-1 stall bins, num_reasons_p instret,
// num_reasons_p+1 cycles, anything else reads 0.
// reason_width_p >= clog2(num_reasons_p), addr_width_p >= clog2(num_reasons_p+2).
module bp_stall_histogram #(
  parameter int unsigned num_reasons_p   = 32,
  parameter int unsigned reason_width_p  = 5,
  parameter int unsigned counter_width_p = 32,
  parameter int unsigned addr_width_p    = 6
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       en_i,
  input  logic                       instret_i,
  input  logic                       reason_v_i,
  input  logic [reason_width_p-1:0]  reason_i,
  input  logic                       snapshot_i,
  input  logic                       clear_i,
  input  logic                       rd_v_i,
  input  logic [addr_width_p-1:0]    rd_addr_i,
  output logic                       rd_ready_o,
  output logic                       rd_v_o,
  output logic [counter_width_p-1:0] rd_data_o,
  input  logic                       rd_yumi_i
);

  logic [counter_width_p-1:0] stall_q [num_reasons_p];
  logic [counter_width_p-1:0] instret_q;
  logic [counter_width_p-1:0] cycle_q;

  logic [counter_width_p-1:0] stall_shadow_q [num_reasons_p];
  logic [counter_width_p-1:0] instret_shadow_q;
  logic [counter_width_p-1:0] cycle_shadow_q;

  function automatic logic [counter_width_p-1:0] sat_inc(input logic [counter_width_p-1:0] v);
    return (v == '1) ? v : v + counter_width_p'(1);
  endfunction

  // One-hot select of the stall bin for this cycle; all-zero when an
  // instruction retired. Invalid or out-of-range reasons fall into bin 0.
  logic [num_reasons_p-1:0] stall_hit;

  always_comb begin
    stall_hit = '0;
    for (int unsigned i = 0; i < num_reasons_p; i++) begin
      if (reason_v_i && (reason_i == reason_width_p'(i))) stall_hit[i] = 1'b1;
    end
    if (instret_i) begin
      stall_hit = '0;
    end else if (stall_hit == '0) begin
      stall_hit[0] = 1'b1;
    end
  end

  // Live bank. Clear wins over the update so the clearing cycle is dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      for (int unsigned i = 0; i < num_reasons_p; i++) stall_q[i] <= '0;
      instret_q <= '0;
      cycle_q   <= '0;
    end else if (en_i) begin
      cycle_q <= sat_inc(cycle_q);
      if (instret_i) instret_q <= sat_inc(instret_q);
      for (int unsigned i = 0; i < num_reasons_p; i++) begin
        if (stall_hit[i]) stall_q[i] <= sat_inc(stall_q[i]);
      end
    end
  end

  // Shadow bank samples the registered live values, so it never includes
  // the increment (or the clear) happening on the same edge.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < num_reasons_p; i++) stall_shadow_q[i] <= '0;
      instret_shadow_q <= '0;
      cycle_shadow_q   <= '0;
    end else if (snapshot_i) begin
      for (int unsigned i = 0; i < num_reasons_p; i++) stall_shadow_q[i] <= stall_q[i];
      instret_shadow_q <= instret_q;
      cycle_shadow_q   <= cycle_q;
    end
  end

  logic [counter_width_p-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < num_reasons_p; i++) begin
      if (rd_addr_i == addr_width_p'(i)) rd_word = stall_shadow_q[i];
    end
    if (rd_addr_i == addr_width_p'(num_reasons_p)) rd_word = instret_shadow_q;
    if (rd_addr_i == addr_width_p'(num_reasons_p + 1)) rd_word = cycle_shadow_q;
  end

  typedef enum logic [0:0] {e_ready, e_valid} rd_state_e;

  rd_state_e                  rd_state_q;
  logic [counter_width_p-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_state_q <= e_ready;
      rd_data_q  <= '0;
    end else begin
      unique case (rd_state_q)
        e_ready: begin
          if (rd_v_i) begin
            rd_data_q  <= rd_word;
            rd_state_q <= e_valid;
          end
        end
        e_valid: begin
          if (rd_yumi_i) rd_state_q <= e_ready;
        end
        default: rd_state_q <= e_ready;
      endcase
    end
  end

  assign rd_ready_o = (rd_state_q == e_ready);
  assign rd_v_o     = (rd_state_q == e_valid);
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_bp_stall_histogram.sv
// Bench for bp_stall_histogram: a full-width instance and a 4-bit-counter
// instance share stimulus. A count-based reference model predicts each read
// word; a monitor pops predictions when the DUT hands over a response.
module tb_bp_stall_histogram;

  localparam int unsigned NR = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i, en_i, instret_i, reason_v_i, snapshot_i, clear_i;
  logic        rd_v_i, rd_yumi_i;
  logic [4:0]  reason_i;
  logic [5:0]  rd_addr_i;
  logic        rd_ready, rd_v, s_rd_ready, s_rd_v;
  logic [31:0] rd_data;
  logic [3:0]  s_rd_data;

  bp_stall_histogram u_dut (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .instret_i(instret_i),
    .reason_v_i(reason_v_i), .reason_i(reason_i), .snapshot_i(snapshot_i),
    .clear_i(clear_i), .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i),
    .rd_ready_o(rd_ready), .rd_v_o(rd_v), .rd_data_o(rd_data), .rd_yumi_i(rd_yumi_i)
  );

  bp_stall_histogram #(.counter_width_p(4)) u_sat (
    .clk_i(clk), .reset_i(reset_i), .en_i(en_i), .instret_i(instret_i),
    .reason_v_i(reason_v_i), .reason_i(reason_i), .snapshot_i(snapshot_i),
    .clear_i(clear_i), .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i),
    .rd_ready_o(s_rd_ready), .rd_v_o(s_rd_v), .rd_data_o(s_rd_data), .rd_yumi_i(rd_yumi_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: unbounded event counts; saturation applied only when predicting.
  longint unsigned m_stall [NR];
  longint unsigned m_ins, m_cyc;
  longint unsigned s_stall [NR];
  longint unsigned s_ins, s_cyc;
  bit              m_busy;
  longint unsigned q32[$];
  longint unsigned q4[$];
  longint unsigned last32, last4;

  function automatic longint unsigned sat(input longint unsigned v, input int w);
    longint unsigned mx = (64'd1 << w) - 64'd1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic longint unsigned shadow_word(input logic [5:0] a);
    if (a < NR) return s_stall[a];
    if (a == NR) return s_ins;
    if (a == NR + 1) return s_cyc;
    return 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model, evaluated mid-cycle on the inputs the next edge samples.
  always @(negedge clk) begin
    if (reset_i) begin
      foreach (m_stall[i]) begin m_stall[i] = 0; s_stall[i] = 0; end
      m_ins = 0; m_cyc = 0; s_ins = 0; s_cyc = 0;
      m_busy = 0;
      q32.delete();
      q4.delete();
    end else begin
      check("rd_ready_o", rd_ready, !m_busy);
      check("rd_v_o", rd_v, m_busy);
      check("sat_rd_ready_o", s_rd_ready, !m_busy);
      check("sat_rd_v_o", s_rd_v, m_busy);
      if (m_busy) begin
        if (rd_yumi_i) m_busy = 0;
      end else if (rd_v_i) begin
        q32.push_back(sat(shadow_word(rd_addr_i), 32));
        q4.push_back(sat(shadow_word(rd_addr_i), 4));
        m_busy = 1;
      end
      if (snapshot_i) begin
        s_stall = m_stall; s_ins = m_ins; s_cyc = m_cyc;
      end
      if (clear_i) begin
        foreach (m_stall[i]) m_stall[i] = 0;
        m_ins = 0; m_cyc = 0;
      end else if (en_i) begin
        m_cyc++;
        if (instret_i) m_ins++;
        else if (reason_v_i && reason_i < NR) m_stall[reason_i]++;
        else m_stall[0]++;
      end
    end
  end

  // Monitor: one prediction consumed per handed-over response.
  always @(negedge clk) begin
    if (!reset_i && rd_v && rd_yumi_i) begin
      if (q32.size() == 0 || q4.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_response: got data %0d with no request outstanding", rd_data);
      end else begin
        check("rd_data_o", rd_data, q32.pop_front());
        check("sat_rd_data_o", s_rd_data, q4.pop_front());
      end
      last32 = rd_data;
      last4  = s_rd_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset_i = 0; en_i = 0; instret_i = 0; reason_v_i = 0; reason_i = 0;
    snapshot_i = 0; clear_i = 0; rd_v_i = 0; rd_addr_i = 0; rd_yumi_i = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_i = 1;
    step();
    step();
    reset_i = 0;
  endtask

  task automatic run(input int n, input logic ins, input logic rv, input logic [4:0] r);
    en_i = 1; instret_i = ins; reason_v_i = rv; reason_i = r;
    repeat (n) step();
    en_i = 0; instret_i = 0; reason_v_i = 0;
  endtask

  task automatic snap();
    snapshot_i = 1;
    step();
    snapshot_i = 0;
  endtask

  task automatic do_read(input logic [5:0] a, input longint unsigned e32, input longint unsigned e4);
    int n = 0;
    rd_v_i = 1; rd_addr_i = a;
    step();
    rd_v_i = 0;
    while (rd_v !== 1'b1 && n < 8) begin step(); n++; end
    if (rd_v !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL read_timeout: addr %0d got no rd_v_o, required 1", a);
    end else begin
      rd_yumi_i = 1;
      step();
      rd_yumi_i = 0;
      check($sformatf("read_addr%0d", a), last32, e32);
      check($sformatf("sat_read_addr%0d", a), last4, e4);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check("reset_rd_ready_o", rd_ready, 1);
    check("reset_rd_v_o", rd_v, 0);
    check("reset_rd_data_o", rd_data, 0);

    // 1: instret and a single reason bin
    run(4, 1, 0, 0);
    run(6, 0, 1, 2);
    snap();
    do_read(2, 6, 6);
    do_read(32, 4, 4);
    do_read(33, 10, 10);

    // 2: no valid reason lands in bin 0; disabled cycles ignored
    do_reset();
    run(5, 0, 0, 0);
    repeat (7) begin
      en_i = 0; instret_i = 1'($urandom); reason_v_i = 1'($urandom); reason_i = 5'($urandom);
      step();
    end
    idle();
    snap();
    do_read(0, 5, 5);
    do_read(33, 5, 5);

    // 3: snapshot+clear together is an atomic read-and-reset
    do_reset();
    run(8, 0, 1, 7);
    en_i = 1; reason_v_i = 1; reason_i = 7; snapshot_i = 1; clear_i = 1;
    step();
    snapshot_i = 0; clear_i = 0;
    run(3, 0, 1, 7);
    do_read(7, 8, 8);
    snap();
    do_read(7, 3, 3);

    // 4: saturation on the narrow instance
    do_reset();
    run(20, 0, 1, 1);
    snap();
    do_read(1, 20, 15);
    do_read(33, 20, 15);

    // 5: unmapped address, then held response across snapshots
    do_reset();
    run(5, 0, 1, 3);
    snap();
    rd_v_i = 1; rd_addr_i = 40;
    step();
    rd_v_i = 0;
    check("addr40_rd_v_o", rd_v, 1);
    check("addr40_rd_data_o", rd_data, 0);
    rd_yumi_i = 1;
    step();
    rd_yumi_i = 0;
    check("addr40_ready_after_yumi", rd_ready, 1);
    rd_v_i = 1; rd_addr_i = 33;
    step();
    rd_v_i = 0;
    en_i = 1; reason_v_i = 1; reason_i = 3;
    for (int k = 0; k < 3; k++) begin
      snapshot_i = ~snapshot_i;
      step();
      check("hold_rd_v_o", rd_v, 1);
      check("hold_rd_ready_o", rd_ready, 0);
      check("hold_rd_data_o", rd_data, 5);
      check("hold_sat_rd_data_o", s_rd_data, 5);
    end
    idle();
    rd_yumi_i = 1;
    step();
    rd_yumi_i = 0;
    check("hold_ready_after_yumi", rd_ready, 1);
    check("hold_v_after_yumi", rd_v, 0);

    // 6: reset drops a pending response and clears the shadow
    do_reset();
    run(4, 0, 1, 5);
    snap();
    rd_v_i = 1; rd_addr_i = 33;
    step();
    rd_v_i = 0;
    check("pre_reset_rd_v_o", rd_v, 1);
    reset_i = 1;
    step();
    reset_i = 0;
    check("post_reset_rd_v_o", rd_v, 0);
    check("post_reset_rd_ready_o", rd_ready, 1);
    check("post_reset_rd_data_o", rd_data, 0);
    snap();
    do_read(33, 0, 0);

    // Random traffic against the model
    do_reset();
    repeat (1500) begin
      reset_i    = ($urandom_range(0, 199) == 0);
      en_i       = ($urandom_range(0, 3) != 0);
      instret_i  = ($urandom_range(0, 2) == 0);
      reason_v_i = ($urandom_range(0, 3) != 0);
      reason_i   = 5'($urandom);
      snapshot_i = ($urandom_range(0, 15) == 0);
      clear_i    = ($urandom_range(0, 63) == 0);
      rd_v_i     = 1'($urandom);
      rd_addr_i  = 6'($urandom_range(0, 40));
      rd_yumi_i  = 1'($urandom);
      step();
    end
    idle();
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bp_stall_histogram.md
Name: bp_stall_histogram

Overview:
- Synthesizable accumulator downstream of the core profiler's per-cycle stall classification.
- Every enabled cycle it consumes either one retired-instruction event or one 5-bit stall-reason code, and bins it into a bank of saturating counters.
- The live counter bank can be snapshotted atomically into a shadow bank.
- The host reads the shadow bank one word at a time over a valid/ready read port, so stall breakdowns are available on FPGA without simulation.

Parameters:
- num_reasons_p, 32, number of stall-reason bins. Reason code 0 is "unknown".
- reason_width_p, 5, width of the reason code; must be at least clog2(num_reasons_p).
- counter_width_p, 32, width of every counter.
- addr_width_p, 6, read address width; must be at least clog2(num_reasons_p+2).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- en_i  in  1  profiling enable. Low freezes all live counters.
- instret_i  in  1  an instruction retired this cycle.
- reason_v_i  in  1  reason_i is valid this cycle.
- reason_i  in  reason_width_p  stall reason code for this cycle.
- snapshot_i  in  1  copy the live bank into the shadow bank.
- clear_i  in  1  zero the live bank.
- rd_v_i  in  1  read request valid.
- rd_addr_i  in  addr_width_p  read address.
- rd_ready_o  out  1  read request accepted when high.
- rd_v_o  out  1  read data valid.
- rd_data_o  out  counter_width_p  read data.
- rd_yumi_i  in  1  consumer takes rd_data_o.

Behaviour:
- Live bank contents:
  - stall[0..num_reasons_p-1]
  - instret_cnt
  - cycle_cnt
- Per-cycle update, when en_i=1 and clear_i=0:
  - cycle_cnt increments.
  - If instret_i=1: instret_cnt increments, and reason_i is ignored.
  - Else if reason_v_i=1 and reason_i < num_reasons_p: stall[reason_i] increments.
  - Else (no valid reason, or reason out of range): stall[0] increments.
- Exactly one of {instret_cnt, stall[*]} increments per enabled cycle. Invariant: cycle_cnt = instret_cnt + sum(stall), as long as nothing has saturated.
- Saturation: every counter holds at 2^counter_width_p-1 and never wraps. Each counter saturates independently; cycle_cnt may saturate while the others keep counting.
- en_i=0: no live counter changes. Snapshot, clear and reads still operate.
- snapshot_i=1 at edge t:
  - The shadow bank receives the live register values as they were before edge t, excluding cycle t's increment.
  - The live update for cycle t still occurs.
- clear_i=1 at edge t:
  - All live counters become 0.
  - Cycle t's event is dropped, not counted.
- snapshot_i and clear_i together: the shadow captures the pre-clear values and the live bank becomes 0. This is an atomic read-and-reset; no event is lost or double-counted beyond the dropped cycle t.
- Read address map, served from the shadow bank only:
  - 0..num_reasons_p-1 → stall[addr]
  - num_reasons_p → instret_cnt
  - num_reasons_p+1 → cycle_cnt
  - any other address → 0
- Read FSM has two states, e_ready and e_valid.
  - e_ready: rd_ready_o=1, rd_v_o=0. On rd_v_i=1, register the shadow word into rd_data_o and go to e_valid. Data appears the cycle after acceptance (1-cycle latency).
  - e_valid: rd_ready_o=0, rd_v_o=1, rd_data_o held stable. On rd_yumi_i=1, go to e_ready. A new request is accepted no earlier than the following cycle, so the maximum throughput is one read per 2 cycles.
  - A snapshot while in e_valid does not alter the held rd_data_o.
- Reset (sync):
  - All live and shadow counters = 0.
  - FSM = e_ready; rd_ready_o=1, rd_v_o=0, rd_data_o=0.
  - Reset mid-read drops the pending response.
- Reset overrides clear, snapshot and en_i.

Test Plan:
1. Reset, en_i=1 for 10 cycles, 4 with instret_i=1 and 6 with reason_v_i=1 reason_i=2; snapshot; read addr 2, 32 and 33 → 6, 4 and 10 respectively.
2. en_i=1 for 5 cycles with reason_v_i=0 and instret_i=0, then en_i=0 for 7 cycles; snapshot; read addr 0 and 33 → 5 and 5.
3. Accumulate 8 cycles of reason 7; assert snapshot_i and clear_i together with reason 7 present; run 3 more cycles of reason 7; read addr 7 → 8. Snapshot again; read addr 7 → 3.
4. Preload via counter_width_p=4 and 20 cycles of reason 1; snapshot; read addr 1 → 15 and addr 33 → 15, with no wrap.
5. rd_v_i with addr 40 → rd_v_o next cycle with data 0. Hold rd_yumi_i=0 for 3 cycles while toggling snapshot_i → rd_v_o stays 1, rd_data_o is unchanged, and rd_ready_o=0 until the cycle after rd_yumi_i.
6. Assert reset_i while in e_valid → next cycle rd_v_o=0, rd_ready_o=1, and a read of addr 33 after snapshot returns 0.
